program_loader: RTL

Boot-time instruction loader that sits directly upstream of the single-cycle processor core. It accepts a length-prefixed byte stream over a valid/ready handshake and packs it big-endian into 32-bit words. Each word is written to instruction memory at consecutive word addresses starting at 0. The block holds the core in reset (`core_rst_n` low) for the whole load and releases it only after the last word is written; a fresh `start` reloads the program.

---
 rtl/program_loader.sv | 111 +++++++++++
 1 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - length-prefixed byte stream to 32-bit instruction memory loader
module program_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_write_en,
    output logic [31:0] imem_write_addr,
    output logic [31:0] imem_write_data,
    output logic        core_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    // Widened by one bit so a full-depth program (len == 2**ADDR_WIDTH) compares cleanly.
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

    logic [2:0]  state;
    logic [15:0] len_q;
    logic [31:0] sr;
    logic [1:0]  byte_idx;
    logic [15:0] count_q;

    logic        xfer;
    logic [15:0] len_next;
    logic [15:0] count_next;
    logic        len_bad;

    assign xfer       = byte_valid && byte_ready;
    assign len_next   = {len_q[15:8], byte_data};
    assign count_next = count_q + 16'd1;
    assign len_bad    = (len_next == 16'd0) || ({1'b0, len_next} > MAX_LEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            len_q    <= 16'd0;
            sr       <= 32'd0;
            byte_idx <= 2'd0;
            count_q  <= 16'd0;
        end else begin
            case (state)
                S_IDLE, S_RUN: begin
                    if (start) begin
                        state   <= S_LEN_HI;
                        count_q <= 16'd0;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_q[15:8] <= byte_data;
                        state       <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_q[7:0] <= byte_data;
                        byte_idx   <= 2'd0;
                        count_q    <= 16'd0;
                        state      <= len_bad ? S_ERROR : S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        sr       <= {sr[23:0], byte_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    count_q <= count_next;
                    state   <= (count_next == len_q) ? S_RUN : S_DATA;
                end
                S_ERROR: begin
                    if (start) begin
                        state <= S_LEN_HI;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Every output is a decode of registered state; the word index doubles as word_count.
    assign byte_ready      = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
    assign imem_write_en   = (state == S_WRITE);
    assign imem_write_addr = imem_write_en ? 32'({count_q[ADDR_WIDTH-1:0], 2'b00}) : 32'd0;
    assign imem_write_data = imem_write_en ? sr : 32'd0;
    assign core_rst_n      = (state == S_RUN);
    assign busy            = byte_ready || imem_write_en;
    assign done            = (state == S_RUN);
    assign error           = (state == S_ERROR);
    assign word_count      = count_q;

endmodule
